// File: rtl/cp0_exception_unit.sv
// CP0 exception unit: SR/Cause/EPC registers, interrupt and exception request, mtc0/mfc0 access.
// Latency: Req, dout and EPCOut are combinational; register updates take effect on the next rising edge.
// Backpressure: none; Req flushes the whole pipeline in the cycle it is raised, and that cycle's mtc0 is dropped.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   en, addr, din       mtc0 write from the M stage (addr also selects the mfc0 read)
//   dout                mfc0 read data (SR=12, Cause=13, EPC=14, others 0)
//   VPC, BDIn           PC of the M-stage instruction and its delay-slot flag
//   ExcCodeIn           synchronous exception code carried to M (0 = none)
//   HWInt               external interrupt lines
//   EXLClr              eret in M; clears SR.EXL
//   EPCOut              EPC register value (eret target)
//   Req                 flush request; the pipeline redirects to 0x0000_4180
//
// Optional feature: define CP0_PRID_EN to make addr 15 read the constant PRId 32'h2023_0007.
module cp0_exception_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    // Only the architecturally implemented bits are stored.
    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic [31:0] w_epc_entry;
    logic        w_wr_sr;
    logic        w_wr_epc;

    assign w_sr    = {16'b0, r_sr_im, 8'b0, r_sr_exl, r_sr_ie};
    assign w_cause = {r_cause_bd, 15'b0, r_cause_ip, 3'b0, r_cause_exc, 2'b0};

    // EXL masks both sources, so no nested exceptions are ever taken.
    assign w_int_req = (|(HWInt & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_sr_exl;
    assign Req       = w_int_req | w_exc_req;

    // A delay-slot instruction restarts at its branch; EPC is always word aligned.
    assign w_epc_entry = (BDIn ? (VPC - 32'd4) : VPC) & 32'hFFFF_FFFC;

    assign w_wr_sr  = en & (addr == 5'd12);
    assign w_wr_epc = en & (addr == 5'd14);

    assign EPCOut = r_epc;

    always_comb begin
        dout = 32'd0;
        case (addr)
            5'd12: dout = w_sr;
            5'd13: dout = w_cause;
            5'd14: dout = r_epc;
`ifdef CP0_PRID_EN
            5'd15: dout = 32'h2023_0007;
`endif
            default: dout = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= 6'd0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= 6'd0;
            r_cause_exc <= 5'd0;
            r_epc       <= 32'd0;
        end else begin
            // Pending-interrupt bits simply track the lines every cycle.
            r_cause_ip <= HWInt;
            if (Req) begin
                // Exception entry; a simultaneous mtc0 or eret is discarded.
                r_sr_exl    <= 1'b1;
                r_cause_bd  <= BDIn;
                r_cause_exc <= w_int_req ? 5'd0 : ExcCodeIn;
                r_epc       <= w_epc_entry;
            end else begin
                if (w_wr_sr) begin
                    r_sr_im  <= din[15:10];
                    r_sr_ie  <= din[0];
                    // eret in the same cycle wins for EXL.
                    r_sr_exl <= EXLClr ? 1'b0 : din[1];
                end else if (EXLClr) begin
                    r_sr_exl <= 1'b0;
                end
                if (w_wr_epc) begin
                    r_epc <= din;
                end
            end
        end
    end

endmodule

// File: doc/cp0_exception_unit.md
CP0_EXCEPTION_UNIT -- requirements
Module: cp0_exception_unit

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 en  input  1  mtc0 write enable from M stage.
REQ-004 addr  input  5  CP0 register number for mtc0/mfc0.
REQ-005 din  input  32  mtc0 write data.
REQ-006 dout  output  32  mfc0 read data, combinational from addr.
REQ-007 VPC  input  32  PC of the instruction currently in M stage.
REQ-008 BDIn  input  1  M-stage instruction sits in a branch delay slot.
REQ-009 ExcCodeIn  input  5  exception code carried to M stage; 0 = none.
REQ-010 HWInt  input  6  external hardware interrupt lines.
REQ-011 EXLClr  input  1  eret in M stage; clears SR.EXL.
REQ-012 EPCOut  output  32  current EPC register value, the eret target.
REQ-013 Req  output  1  combinational flush request to all pipeline registers; pipeline PC redirects to 0x0000_4180.

Function
REQ-014 SR (reg 12) SHALL store only IM[15:10], EXL[1] and IE[0]; all other bits read 0.
REQ-015 Cause (reg 13) SHALL hold BD[31], IP[15:10] and ExcCode[6:2]; all other bits read 0; Cause is read-only to mtc0.
REQ-016 EPC (reg 14) SHALL be a full 32-bit register, written by mtc0 or on exception entry.
REQ-017 IntReq = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL, combinational.
REQ-018 ExcReq = (ExcCodeIn != 0) & ~SR.EXL, combinational.
REQ-019 Req = IntReq | ExcReq in the same cycle, with no register stage.
REQ-020 On a clock edge with Req=1: SR.EXL<=1; Cause.BD<=BDIn; Cause.ExcCode<= IntReq ? 0 : ExcCodeIn; EPC<= BDIn ? VPC-4 : VPC, with bits [1:0] of the written EPC forced to 0.
REQ-021 Interrupt SHALL take priority over a simultaneous synchronous exception, recording ExcCode 0.
REQ-022 Cause.IP SHALL load HWInt on every non-reset edge, independent of Req, en and EXL.
REQ-023 With en=1 and Req=0, addr 12 SHALL update SR under mask (bits 15:10, 1, 0) and addr 14 SHALL update EPC; writes to any other addr SHALL be ignored.
REQ-024 Req=1 in the same cycle as en=1 SHALL suppress the mtc0 write entirely.
REQ-025 EXLClr=1 with Req=0 SHALL clear SR.EXL on the edge; Req=1 and EXLClr=1 together SHALL leave EXL=1.
REQ-026 mtc0 to SR and EXLClr in the same cycle: the EXLClr clear SHALL win for bit 1; the other SR bits take din.
REQ-027 dout SHALL return SR, Cause or EPC for addr 12/13/14 and 0 for every other address.
REQ-028 EPCOut SHALL equal the EPC register with no bypass; a mtc0 to EPC becomes visible on EPCOut the following cycle.
REQ-029 While SR.EXL=1, Req SHALL remain 0 regardless of HWInt or ExcCodeIn. No nested exceptions.

Reset
REQ-030 On reset, SR, Cause and EPC SHALL all clear to 0, so Req=0, dout=0 and EPCOut=0 in the following cycle.
REQ-031 Reset SHALL override Req, en and EXLClr on the same edge.

Configuration
REQ-032 Macro CP0_PRID_EN: when defined, addr 15 SHALL read constant PRId 32'h2023_0007 and ignore mtc0 writes.
REQ-033 When CP0_PRID_EN is undefined, addr 15 SHALL read 0, like any other unimplemented register.

Verification
REQ-034 After reset, with addr=12, 13 and 14 in turn: dout=0 each time, Req=0 and EPCOut=0.
REQ-035 Take an exception: en=1, addr=12, din=32'hFFFF_FFFF, then ExcCodeIn=5'd4, VPC=32'h3010, BDIn=0, with SR.EXL still 0 (mtc0 alone sets EXL, so clear it first or write din=32'h0000_FC01). Required: Req=1 in that cycle, then EPC=32'h3010, Cause=32'h0000_0010 and SR.EXL=1.
REQ-036 Interrupt in a delay slot: SR=32'h0000_0401, HWInt=6'b000001, VPC=32'h3024, BDIn=1, ExcCodeIn=5'd10. Required: Req=1, then EPC=32'h3020, Cause[31]=1, ExcCode=0 and IP=6'b000001.
REQ-037 While EXL=1, assert HWInt=6'h3F and ExcCodeIn=5'd12. Required: Req=0. Then pulse EXLClr=1 for one cycle. Required: EXL=0 and Req=1 in the next cycle.
REQ-038 Same cycle: Req=1 (ExcCodeIn=5'd8) with en=1, addr=14, din=32'hDEAD_BEEF. Required: EPC=VPC and not 32'hDEAD_BEEF.
REQ-039 Read addr=15: dout=32'h2023_0007 with CP0_PRID_EN defined, and 0 without it.
